// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end.
// Fetch FSM states, word type and reset defaults.
package mips_pkg;

  typedef logic [31:0] word_t;

  localparam word_t       MIPS_NOP     = 32'h0000_0000;
  localparam word_t       DEF_RESET_PC = 32'h0000_0000;
  localparam int unsigned DEF_PC_STEP  = 4;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: reset load, sequential step, aligned redirect load.
// Also raises a sticky flag when a redirect target is misaligned.
module fetch_pc_reg
  import mips_pkg::*;
#(
  parameter word_t       RESET_PC = DEF_RESET_PC,
  parameter int unsigned PC_STEP  = DEF_PC_STEP
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  i_step,
  input  logic  i_redir,
  input  word_t i_redir_pc,
  output word_t o_pc,
  output logic  o_misalign
);

  word_t r_pc;
  logic  r_misalign;
  word_t w_step;

  assign w_step = word_t'(PC_STEP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else if (i_redir) begin
      r_pc <= {i_redir_pc[31:2], 2'b00};
      if (|i_redir_pc[1:0])
        r_misalign <= 1'b1;
    end else if (i_step) begin
      r_pc <= r_pc + w_step;
    end
  end

  assign o_pc       = r_pc;
  assign o_misalign = r_misalign;

endmodule

// File: rtl/mips_fetch_stage.sv
// Instruction fetch stage: PC, imem handshake, one-entry IR slot.
// Define FETCH_PERF_CNT_EN to add fetch_count/stall_count outputs.
module mips_fetch_stage
  import mips_pkg::*;
#(
  parameter word_t       RESET_PC = DEF_RESET_PC,
  parameter int unsigned PC_STEP  = DEF_PC_STEP
) (
  input  logic  clk,
  input  logic  reset,
  output logic  imem_req,
  output word_t imem_addr,
  input  logic  imem_ready,
  input  word_t imem_rdata,
  input  logic  stall,
  input  logic  redirect_valid,
  input  word_t redirect_pc,
  output word_t IR,
  output logic  ir_valid,
  output word_t ir_pc,
  output word_t ir_pc_plus4,
  output logic  misalign_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output word_t fetch_count,
  output word_t stall_count
`endif
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  word_t r_ir;
  word_t r_ir_pc;
  word_t r_ir_pc4;
  logic  r_ir_valid;

  word_t w_pc;
  logic  w_req;
  logic  w_redir;
  logic  w_fill;
  logic  w_consume;

  // Redirects are ignored during the post-reset bubble.
  assign w_redir   = redirect_valid && (r_state != S_BOOT);
  assign w_consume = r_ir_valid && !stall;

  always_comb begin
    w_req       = 1'b0;
    w_state_nxt = r_state;
    unique case (r_state)
      S_BOOT: w_state_nxt = S_RUN;
      S_RUN: begin
        w_req = !redirect_valid && (!r_ir_valid || !stall);
        if (stall && r_ir_valid)
          w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (!stall)
          w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_BOOT;
    endcase
    if (w_redir)
      w_state_nxt = S_RUN;
  end

  assign imem_req  = w_req && !reset;
  assign imem_addr = w_pc;
  assign w_fill    = imem_req && imem_ready;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk        (clk),
    .reset      (reset),
    .i_step     (w_fill),
    .i_redir    (w_redir),
    .i_redir_pc (redirect_pc),
    .o_pc       (w_pc),
    .o_misalign (misalign_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_BOOT;
      r_ir       <= MIPS_NOP;
      r_ir_pc    <= '0;
      r_ir_pc4   <= '0;
      r_ir_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_redir) begin
        r_ir       <= MIPS_NOP;
        r_ir_valid <= 1'b0;
      end else if (w_fill) begin
        r_ir       <= imem_rdata;
        r_ir_pc    <= w_pc;
        r_ir_pc4   <= w_pc + word_t'(PC_STEP);
        r_ir_valid <= 1'b1;
      end else if (w_consume) begin
        r_ir       <= MIPS_NOP;
        r_ir_valid <= 1'b0;
      end
    end
  end

  assign IR          = r_ir;
  assign ir_valid    = r_ir_valid;
  assign ir_pc       = r_ir_pc;
  assign ir_pc_plus4 = r_ir_pc4;

`ifdef FETCH_PERF_CNT_EN
  word_t r_fetch_cnt;
  word_t r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_fill && (r_fetch_cnt != '1))
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (r_ir_valid && stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fetch_count = r_fetch_cnt;
  assign stall_count = r_stall_cnt;
`endif

endmodule
